// File: rtl/lcplc_axis_last_generator_if.sv
// Stream bundle between the raw sample source, the last-flag generator and
// the LCPLC coder. The "master" modport is the generator's view: it accepts
// the raw stream and drives the flagged stream. The "slave" modport is the
// surrounding environment (source on the input side, coder on the output side).
interface lcplc_axis_last_generator_if #(
  parameter int DATA_WIDTH = 16
);
  // Raw sample stream into the generator
  logic                  input_valid;
  logic                  input_ready;
  logic [DATA_WIDTH-1:0] input_data;

  // Flagged sample stream out of the generator
  logic                  output_valid;
  logic                  output_ready;
  logic [DATA_WIDTH-1:0] output_data;
  logic                  output_last_r;
  logic                  output_last_s;
  logic                  output_last_b;
  logic                  output_last_i;

  modport master (
    input  input_valid,
    input  input_data,
    output input_ready,
    output output_valid,
    output output_data,
    output output_last_r,
    output output_last_s,
    output output_last_b,
    output output_last_i,
    input  output_ready
  );

  modport slave (
    output input_valid,
    output input_data,
    input  input_ready,
    input  output_valid,
    input  output_data,
    input  output_last_r,
    input  output_last_s,
    input  output_last_b,
    input  output_last_i,
    output output_ready
  );
endinterface

// File: rtl/lcplc_axis_last_generator.sv
// LCPLC last-flag generator.
// Walks column/row/band/block counters over a raw sample stream and tags
// each sample with nested last_r/last_s/last_b/last_i flags derived from the
// image geometry latched at the first sample of every image. A main register
// plus a one-entry skid register give a fully registered output with
// 1 sample/cycle throughput and no combinational ready path.
module lcplc_axis_last_generator #(
  parameter int DATA_WIDTH         = 16,
  parameter int MAX_BLOCK_SIZE_LOG = 8,
  parameter int BAND_WIDTH         = 10,
  parameter int BLOCK_COUNT_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [MAX_BLOCK_SIZE_LOG-1:0] cfg_block_rows_m1,
  input  logic [MAX_BLOCK_SIZE_LOG-1:0] cfg_block_cols_m1,
  input  logic [BAND_WIDTH-1:0]         cfg_bands_m1,
  input  logic [BLOCK_COUNT_WIDTH-1:0]  cfg_blocks_m1,
  lcplc_axis_last_generator_if.master   bus,
  output logic                          image_done,
  output logic                          busy
);

  // Flag bit positions, innermost (row) to outermost (image)
  localparam int NUM_FLAGS = 4;
  localparam int FLAG_R    = 0;
  localparam int FLAG_S    = 1;
  localparam int FLAG_B    = 2;
  localparam int FLAG_I    = 3;

  typedef struct packed {
    logic [NUM_FLAGS-1:0]  flags;
    logic [DATA_WIDTH-1:0] data;
  } beat_t;

  // Position counters inside the image
  logic [MAX_BLOCK_SIZE_LOG-1:0] col_q, col_d;
  logic [MAX_BLOCK_SIZE_LOG-1:0] row_q, row_d;
  logic [BAND_WIDTH-1:0]         band_q, band_d;
  logic [BLOCK_COUNT_WIDTH-1:0]  blk_q, blk_d;

  // Geometry shadow registers, valid for the image in progress
  logic [MAX_BLOCK_SIZE_LOG-1:0] rows_m1_q, rows_m1_d;
  logic [MAX_BLOCK_SIZE_LOG-1:0] cols_m1_q, cols_m1_d;
  logic [BAND_WIDTH-1:0]         bands_m1_q, bands_m1_d;
  logic [BLOCK_COUNT_WIDTH-1:0]  blocks_m1_q, blocks_m1_d;

  // Output stage: main register feeds the port, skid catches one overflow beat
  beat_t main_q, main_d;
  logic  main_valid_q, main_valid_d;
  beat_t skid_q, skid_d;
  logic  skid_valid_q, skid_valid_d;
  logic  input_ready_q, input_ready_d;

  // Status
  logic image_done_q, image_done_d;
  logic busy_q, busy_d;

  // Per-handshake helpers
  logic                          in_fire;
  logic                          out_fire;
  logic                          image_start;
  logic [MAX_BLOCK_SIZE_LOG-1:0] rows_m1_eff;
  logic [MAX_BLOCK_SIZE_LOG-1:0] cols_m1_eff;
  logic [BAND_WIDTH-1:0]         bands_m1_eff;
  logic [BLOCK_COUNT_WIDTH-1:0]  blocks_m1_eff;
  logic [NUM_FLAGS-1:0]          level_match;
  logic [NUM_FLAGS-1:0]          flag;
  beat_t                         in_beat;

  assign in_fire     = bus.input_valid & input_ready_q;
  assign out_fire    = main_valid_q & bus.output_ready;
  assign image_start = (col_q == '0) && (row_q == '0) && (band_q == '0) && (blk_q == '0);

  // The first sample of an image already uses the geometry presented on cfg_*;
  // afterwards the shadow copy is used so mid-image cfg changes are ignored.
  assign rows_m1_eff   = image_start ? cfg_block_rows_m1 : rows_m1_q;
  assign cols_m1_eff   = image_start ? cfg_block_cols_m1 : cols_m1_q;
  assign bands_m1_eff  = image_start ? cfg_bands_m1      : bands_m1_q;
  assign blocks_m1_eff = image_start ? cfg_blocks_m1     : blocks_m1_q;

  // Each counter level is at its terminal value
  assign level_match[FLAG_R] = (col_q  == cols_m1_eff);
  assign level_match[FLAG_S] = (row_q  == rows_m1_eff);
  assign level_match[FLAG_B] = (band_q == bands_m1_eff);
  assign level_match[FLAG_I] = (blk_q  == blocks_m1_eff);

  // Nesting: a level is "last" only if every inner level is also last
  assign flag[0] = level_match[0];
  generate
    for (genvar gi = 1; gi < NUM_FLAGS; gi++) begin : g_flag_chain
      assign flag[gi] = flag[gi-1] & level_match[gi];
    end
  endgenerate

  assign in_beat.flags = flag;
  assign in_beat.data  = bus.input_data;

  // Counter and geometry-shadow next state
  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    band_d      = band_q;
    blk_d       = blk_q;
    rows_m1_d   = rows_m1_q;
    cols_m1_d   = cols_m1_q;
    bands_m1_d  = bands_m1_q;
    blocks_m1_d = blocks_m1_q;

    if (in_fire && image_start) begin
      rows_m1_d   = cfg_block_rows_m1;
      cols_m1_d   = cfg_block_cols_m1;
      bands_m1_d  = cfg_bands_m1;
      blocks_m1_d = cfg_blocks_m1;
    end

    if (in_fire) begin
      col_d = flag[FLAG_R] ? '0 : col_q + MAX_BLOCK_SIZE_LOG'(1);
      if (flag[FLAG_R]) begin
        row_d = flag[FLAG_S] ? '0 : row_q + MAX_BLOCK_SIZE_LOG'(1);
      end
      if (flag[FLAG_S]) begin
        band_d = flag[FLAG_B] ? '0 : band_q + BAND_WIDTH'(1);
      end
      if (flag[FLAG_B]) begin
        blk_d = flag[FLAG_I] ? '0 : blk_q + BLOCK_COUNT_WIDTH'(1);
      end
    end
  end

  // Main/skid next state; ready depends only on registered skid occupancy
  always_comb begin
    main_d       = main_q;
    main_valid_d = main_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;

    if (out_fire || !main_valid_q) begin
      // Main is free this cycle: refill from skid first to keep order
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else if (in_fire) begin
        main_d       = in_beat;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      // Main is stalled: park the accepted beat in skid
      skid_d       = in_beat;
      skid_valid_d = 1'b1;
    end

    input_ready_d = !skid_valid_d;
  end

  // Image status next state
  always_comb begin
    image_done_d = out_fire & main_q.flags[FLAG_I];
    busy_d       = busy_q;
    if (out_fire && main_q.flags[FLAG_I]) begin
      // Anything already accepted behind the last_i beat belongs to the next image
      busy_d = skid_valid_q | in_fire;
    end else if (in_fire && image_start) begin
      busy_d = 1'b1;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q         <= '0;
      row_q         <= '0;
      band_q        <= '0;
      blk_q         <= '0;
      rows_m1_q     <= '0;
      cols_m1_q     <= '0;
      bands_m1_q    <= '0;
      blocks_m1_q   <= '0;
      main_q        <= '0;
      main_valid_q  <= 1'b0;
      skid_q        <= '0;
      skid_valid_q  <= 1'b0;
      input_ready_q <= 1'b1;
      image_done_q  <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      col_q         <= col_d;
      row_q         <= row_d;
      band_q        <= band_d;
      blk_q         <= blk_d;
      rows_m1_q     <= rows_m1_d;
      cols_m1_q     <= cols_m1_d;
      bands_m1_q    <= bands_m1_d;
      blocks_m1_q   <= blocks_m1_d;
      main_q        <= main_d;
      main_valid_q  <= main_valid_d;
      skid_q        <= skid_d;
      skid_valid_q  <= skid_valid_d;
      input_ready_q <= input_ready_d;
      image_done_q  <= image_done_d;
      busy_q        <= busy_d;
    end
  end

  assign bus.input_ready   = input_ready_q;
  assign bus.output_valid  = main_valid_q;
  assign bus.output_data   = main_q.data;
  assign bus.output_last_r = main_q.flags[FLAG_R];
  assign bus.output_last_s = main_q.flags[FLAG_S];
  assign bus.output_last_b = main_q.flags[FLAG_B];
  assign bus.output_last_i = main_q.flags[FLAG_I];
  assign image_done        = image_done_q;
  assign busy              = busy_q;

endmodule

// File: tb/tb_lcplc_axis_last_generator.sv
// Directed bench for lcplc_axis_last_generator: streams images of known
// geometry and checks data order, nested flags, image_done, busy, latency
// and output holding under backpressure against index-derived expectations.
module tb_lcplc_axis_last_generator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  cfg_block_rows_m1 = '0;
  logic [7:0]  cfg_block_cols_m1 = '0;
  logic [9:0]  cfg_bands_m1 = '0;
  logic [15:0] cfg_blocks_m1 = '0;
  logic        image_done;
  logic        busy;

  lcplc_axis_last_generator_if #(.DATA_WIDTH(16)) bus ();

  lcplc_axis_last_generator #(
    .DATA_WIDTH(16),
    .MAX_BLOCK_SIZE_LOG(8),
    .BAND_WIDTH(10),
    .BLOCK_COUNT_WIDTH(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cfg_block_rows_m1(cfg_block_rows_m1),
    .cfg_block_cols_m1(cfg_block_cols_m1),
    .cfg_bands_m1(cfg_bands_m1),
    .cfg_blocks_m1(cfg_blocks_m1),
    .bus(bus),
    .image_done(image_done),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_compared   = 0;
  int n_mismatched = 0;

  // Model geometry (counts, not minus-one) and position inside current image
  int m_r, m_c, m_b, m_k;
  int m_n = 0;

  logic [19:0] exp_q[$];
  logic        lat_chk   = 1'b0;
  logic        acc_prev  = 1'b0;
  logic        stall_prev = 1'b0;
  logic [19:0] prev_beat = '0;
  logic        done_exp  = 1'b0;

  int cnt_r, cnt_s, cnt_b, cnt_i, cnt_done, cnt_irdy_low;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected flags {i,b,s,r} for sample n of an image, from its linear index
  function automatic logic [3:0] exp_flags(input int n);
    int row_len, slice_len, block_len, total;
    row_len   = m_c;
    slice_len = m_c * m_r;
    block_len = slice_len * m_b;
    total     = block_len * m_k;
    exp_flags[0] = ((n % row_len) == row_len - 1);
    exp_flags[1] = ((n % slice_len) == slice_len - 1);
    exp_flags[2] = ((n % block_len) == block_len - 1);
    exp_flags[3] = (n == total - 1);
  endfunction

  task automatic set_geom(input int r_m1, input int c_m1, input int b_m1, input int k_m1);
    cfg_block_rows_m1 = 8'(r_m1);
    cfg_block_cols_m1 = 8'(c_m1);
    cfg_bands_m1      = 10'(b_m1);
    cfg_blocks_m1     = 16'(k_m1);
    m_r = r_m1 + 1;
    m_c = c_m1 + 1;
    m_b = b_m1 + 1;
    m_k = k_m1 + 1;
  endtask

  task automatic clear_counts();
    cnt_r = 0; cnt_s = 0; cnt_b = 0; cnt_i = 0; cnt_done = 0; cnt_irdy_low = 0;
  endtask

  // One clock cycle: drive at the falling edge, observe, then wait a cycle
  task automatic tick(input logic v, input logic [15:0] d, input logic ordy, output logic acc);
    logic [19:0] beat;
    logic [3:0]  oflags;
    logic        done_next;
    bus.input_valid  = v;
    bus.input_data   = d;
    bus.output_ready = ordy;
    #1;
    oflags = {bus.output_last_i, bus.output_last_b, bus.output_last_s, bus.output_last_r};
    done_next = 1'b0;
    if (stall_prev) begin
      check_eq("hold_valid", 32'(bus.output_valid), 32'd1);
      check_eq("hold_beat", 32'({oflags, bus.output_data}), 32'(prev_beat));
    end
    if (done_exp || image_done) check_eq("image_done", 32'(image_done), 32'(done_exp));
    if (image_done) cnt_done++;
    if (!bus.input_ready) cnt_irdy_low++;
    if (lat_chk) check_eq("latency", 32'(bus.output_valid), 32'(acc_prev));
    acc = v & bus.input_ready;
    if (bus.output_valid && ordy) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_out", 32'(bus.output_data), 32'hdead_beef);
      end else begin
        beat = exp_q.pop_front();
        check_eq("data", 32'(bus.output_data), 32'(beat[15:0]));
        check_eq("flags", 32'(oflags), 32'(beat[19:16]));
      end
      cnt_r += int'(oflags[0]);
      cnt_s += int'(oflags[1]);
      cnt_b += int'(oflags[2]);
      cnt_i += int'(oflags[3]);
      done_next = oflags[3];
    end
    if (acc) begin
      exp_q.push_back({exp_flags(m_n), d});
      m_n++;
      if (m_n == m_c * m_r * m_b * m_k) m_n = 0;
    end
    stall_prev = bus.output_valid & !ordy;
    prev_beat  = {oflags, bus.output_data};
    acc_prev   = acc;
    done_exp   = done_next;
    @(negedge clk);
  endtask

  // Send count samples with data base..; pat 0 = ready always, 1 = 1 high / 2 low
  task automatic send(input int count, input int base, input int pat);
    int   sent;
    int   cyc;
    logic rdy;
    logic acc;
    sent = 0;
    cyc  = 0;
    while (sent < count && cyc < count * 4 + 50) begin
      rdy = (pat == 0) ? 1'b1 : ((cyc % 3) == 0);
      tick(1'b1, 16'(base + sent), rdy, acc);
      if (acc) sent++;
      cyc++;
    end
    check_eq("sent_count", 32'(sent), 32'(count));
  endtask

  task automatic drain();
    int   guard;
    logic acc;
    guard = 0;
    while (exp_q.size() > 0 && guard < 100) begin
      tick(1'b0, 16'h0, 1'b1, acc);
      guard++;
    end
    check_eq("drain_empty", 32'(exp_q.size()), 32'd0);
    tick(1'b0, 16'h0, 1'b1, acc);
    tick(1'b0, 16'h0, 1'b1, acc);
  endtask

  initial begin
    bus.input_valid  = 1'b0;
    bus.input_data   = '0;
    bus.output_ready = 1'b0;
    set_geom(0, 0, 0, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("rst_out_valid", 32'(bus.output_valid), 32'd0);
    check_eq("rst_in_ready", 32'(bus.input_ready), 32'd1);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_image_done", 32'(image_done), 32'd0);
    check_eq("rst_flags", 32'({bus.output_last_i, bus.output_last_b, bus.output_last_s, bus.output_last_r}), 32'd0);
    @(negedge clk);

    // Basic image, 24 samples, no backpressure
    $display("test1: rows=2 cols=3 bands=2 blocks=2, ready high");
    set_geom(1, 2, 1, 1);
    clear_counts();
    lat_chk = 1'b1;
    send(12, 0, 0);
    check_eq("busy_mid", 32'(busy), 32'd1);
    send(12, 12, 0);
    drain();
    check_eq("t1_last_r", 32'(cnt_r), 32'd8);
    check_eq("t1_last_s", 32'(cnt_s), 32'd4);
    check_eq("t1_last_b", 32'(cnt_b), 32'd2);
    check_eq("t1_last_i", 32'(cnt_i), 32'd1);
    check_eq("t1_done", 32'(cnt_done), 32'd1);
    check_eq("t1_busy_end", 32'(busy), 32'd0);

    // Same image under 1-high/2-low backpressure
    $display("test2: same geometry, ready 1 high / 2 low");
    clear_counts();
    lat_chk = 1'b0;
    send(24, 0, 1);
    drain();
    check_eq("t2_last_r", 32'(cnt_r), 32'd8);
    check_eq("t2_last_s", 32'(cnt_s), 32'd4);
    check_eq("t2_last_b", 32'(cnt_b), 32'd2);
    check_eq("t2_last_i", 32'(cnt_i), 32'd1);
    check_eq("t2_done", 32'(cnt_done), 32'd1);
    check_eq("t2_ready_dropped", 32'(cnt_irdy_low > 0), 32'd1);

    // Degenerate geometry: every sample is a whole image
    $display("test3: all m1 = 0, 5 samples");
    set_geom(0, 0, 0, 0);
    clear_counts();
    lat_chk = 1'b1;
    send(5, 100, 0);
    drain();
    check_eq("t3_last_r", 32'(cnt_r), 32'd5);
    check_eq("t3_last_i", 32'(cnt_i), 32'd5);
    check_eq("t3_done", 32'(cnt_done), 32'd5);
    check_eq("t3_busy_end", 32'(busy), 32'd0);

    // cfg change mid-image only affects the following image
    $display("test4: cols_m1 2->3 after sample 4");
    set_geom(1, 2, 1, 1);
    clear_counts();
    send(5, 200, 0);
    cfg_block_cols_m1 = 8'd3;
    send(19, 205, 0);
    check_eq("t4_model_at_start", 32'(m_n), 32'd0);
    m_c = 4;
    send(32, 224, 0);
    drain();
    check_eq("t4_last_r", 32'(cnt_r), 32'd16);
    check_eq("t4_last_i", 32'(cnt_i), 32'd2);
    check_eq("t4_done", 32'(cnt_done), 32'd2);

    // Reset mid-image after sample 10
    $display("test5: reset after sample 10");
    set_geom(1, 2, 1, 1);
    clear_counts();
    send(11, 300, 0);
    check_eq("t5_busy_pre", 32'(busy), 32'd1);
    bus.output_ready = 1'b0;
    bus.input_valid  = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("t5_out_valid", 32'(bus.output_valid), 32'd0);
    check_eq("t5_busy", 32'(busy), 32'd0);
    check_eq("t5_in_ready", 32'(bus.input_ready), 32'd1);
    exp_q.delete();
    m_n = 0;
    acc_prev = 1'b0;
    stall_prev = 1'b0;
    done_exp = 1'b0;
    clear_counts();
    send(24, 400, 0);
    drain();
    check_eq("t5_last_s", 32'(cnt_s), 32'd4);
    check_eq("t5_last_i", 32'(cnt_i), 32'd1);

    // Widest column count with several rows and bands
    $display("test6: rows=4 cols=256 bands=2 blocks=1");
    set_geom(3, 255, 1, 0);
    clear_counts();
    send(2048, 0, 0);
    drain();
    check_eq("t6_last_r", 32'(cnt_r), 32'd8);
    check_eq("t6_last_s", 32'(cnt_s), 32'd2);
    check_eq("t6_last_b", 32'(cnt_b), 32'd1);
    check_eq("t6_last_i", 32'(cnt_i), 32'd1);
    check_eq("t6_done", 32'(cnt_done), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
